// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with a runtime-loadable pattern,
// overlapping or non-overlapping detection and a saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i,
  input  logic                         en,
  input  logic                         pat_load,
  input  logic [PAT_W-1:0]             pat_in,
  output logic                         out,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(PAT_W+1)-1:0]   fill
);

  localparam int                 FW       = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]      FILL_MAX = FW'(PAT_W);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_r;
  logic [PAT_W-1:0] win_r;
  logic [PAT_W-1:0] win_next_s;
  logic [FW-1:0]    fill_next_s;
  logic             hit_s;

  // Post-shift window, post-increment fill and the match condition on them.
  always_comb begin
    win_next_s = {win_r[PAT_W-2:0], i};
    if (fill == FILL_MAX) begin
      fill_next_s = FILL_MAX;
    end else begin
      fill_next_s = fill + FW'(1);
    end
    hit_s = (win_next_s == pat_r) && (fill_next_s == FILL_MAX);
  end

  // State update: reset beats pattern load, which beats a qualified bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= PATTERN;
      win_r     <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else if (pat_load) begin
      pat_r <= pat_in;
      win_r <= '0;
      fill  <= '0;
      out   <= 1'b0;
    end else if (en) begin
      win_r <= win_next_s;
      out   <= hit_s;
      // Non-overlapping mode restarts the fill so no bit is shared.
      if (hit_s && !OVERLAP) begin
        fill <= '0;
      end else begin
        fill <= fill_next_s;
      end
      if (hit_s && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end else begin
        match_cnt <= match_cnt;
      end
    end else begin
      out <= 1'b0;
    end
  end

endmodule
